apb_rr_master: RTL and testbench



---
 rtl/apb_rr_master.sv | 155 +++++++++++++++
 tb/tb_apb_rr_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master.sv
// apb_rr_master: two-requester round-robin arbiter driving an APB master
// sequencer (IDLE -> SETUP -> ACCESS) towards two slaves selected by the
// address MSB. A hung slave is cut off after TIMEOUT wait cycles.
module apb_rr_master #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          pclk,
    input  logic          preset,
    // requester 0
    input  logic          req0_valid,
    input  logic          req0_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp0_err,
    // requester 1
    input  logic          req1_valid,
    input  logic          req1_write,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          rsp1_err,
    // APB master side
    output logic [1:0]    psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata0,
    input  logic          pready0,
    input  logic          pslverr0,
    input  logic [DW-1:0] prdata1,
    input  logic          pready1,
    input  logic          pslverr1
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state;
    logic          rr_ptr;
    logic          gnt;
    logic [TW-1:0] tcnt;

    logic          win;
    logic          any_valid;
    logic          win_write;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          sel_ready;
    logic          sel_err;
    logic [DW-1:0] sel_rdata;
    logic          finish;
    logic [DW-1:0] fin_rdata;
    logic          fin_err;

    // Arbitration: pointer holder wins a tie, a lone requester always wins
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            win = rr_ptr;
        else
            win = !req0_valid;
        win_write  = win ? req1_write : req0_write;
        win_addr   = win ? req1_addr  : req0_addr;
        win_wdata  = win ? req1_wdata : req0_wdata;
        req0_ready = (state == IDLE) && !preset && req0_valid && !win;
        req1_ready = (state == IDLE) && !preset && req1_valid &&  win;
    end

    // Only the addressed slave's response lines matter; decide how ACCESS ends
    always_comb begin
        sel_ready = paddr[AW-1] ? pready1  : pready0;
        sel_err   = paddr[AW-1] ? pslverr1 : pslverr0;
        sel_rdata = paddr[AW-1] ? prdata1  : prdata0;
        finish    = sel_ready || (tcnt == TW'(TIMEOUT - 1));
        fin_rdata = (sel_ready && !pwrite) ? sel_rdata : '0;
        fin_err   = sel_ready ? sel_err : 1'b1;
    end

    // Sequencer FSM with registered APB and response outputs
    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            gnt        <= 1'b0;
            tcnt       <= '0;
            psel       <= '0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt     <= win;
                        rr_ptr  <= ~win;
                        pwrite  <= win_write;
                        paddr   <= win_addr;
                        pwdata  <= win_wdata;
                        psel    <= {win_addr[AW-1], ~win_addr[AW-1]};
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    tcnt    <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (finish) begin
                        psel    <= '0;
                        penable <= 1'b0;
                        tcnt    <= '0;
                        state   <= IDLE;
                        if (gnt) begin
                            rsp1_valid <= 1'b1;
                            rsp1_rdata <= fin_rdata;
                            rsp1_err   <= fin_err;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_rdata <= fin_rdata;
                            rsp0_err   <= fin_err;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: randomized bench for apb_rr_master with a
// transaction-level reference model (arbitration by pointer, response
// predicted from wait count, timeout limit and slave data).
module tb_apb_rr_master;

    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    logic          pclk = 1'b0;
    logic          preset;
    logic          req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, rsp0_rdata;
    logic          req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, rsp1_rdata;
    logic [1:0]    psel;
    logic          penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata0, prdata1;
    logic          pready0, pslverr0, pready1, pslverr1;

    int checks = 0;
    int errors = 0;

    // model state: pending commands per requester and round-robin pointer
    bit            pend   [2];
    logic          c_wr   [2];
    logic [AW-1:0] c_addr [2];
    logic [DW-1:0] c_data [2];
    int            ptr;

    apb_rr_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset(preset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata0(prdata0), .pready0(pready0), .pslverr0(pslverr0),
        .prdata1(prdata1), .pready1(pready1), .pslverr1(pslverr1)
    );

    always #5 pclk = ~pclk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req();
        req0_valid = pend[0]; req0_write = c_wr[0]; req0_addr = c_addr[0]; req0_wdata = c_data[0];
        req1_valid = pend[1]; req1_write = c_wr[1]; req1_addr = c_addr[1]; req1_wdata = c_data[1];
    endtask

    // random junk on both slaves, then the selected one gets the intended values
    task automatic drive_slaves(input int sel, input logic rdy, input logic [DW-1:0] rd, input logic se);
        prdata0 = DW'($urandom); pready0 = 1'($urandom); pslverr0 = 1'($urandom);
        prdata1 = DW'($urandom); pready1 = 1'($urandom); pslverr1 = 1'($urandom);
        if (sel == 0) begin prdata0 = rd; pready0 = rdy; pslverr0 = se; end
        else if (sel == 1) begin prdata1 = rd; pready1 = rdy; pslverr1 = se; end
    endtask

    task automatic issue(input int n, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[n] = 1'b1; c_wr[n] = wr; c_addr[n] = a; c_data[n] = d;
    endtask

    task automatic idle_cycle();
        drive_req();
        drive_slaves(-1, 1'b0, '0, 1'b0);
        #1;
        check("idle_ready0", req0_ready, 0);
        check("idle_ready1", req1_ready, 0);
        check("idle_psel", psel, 0);
        @(negedge pclk);
    endtask

    // One transfer from the grant cycle up to the response cycle (or to the
    // cycle after a reset pulse at ACCESS cycle rst_k, if rst_k > 0).
    task automatic serve(input int w, input logic [DW-1:0] rd, input logic se,
                         input int rst_k, output int win);
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            sel, n_acc;
        bit            tmo;
        if (pend[0] && pend[1]) win = ptr;
        else win = pend[0] ? 0 : 1;
        ptr = 1 - win;
        wr = c_wr[win]; a = c_addr[win]; d = c_data[win];
        sel = int'(a[AW-1]);
        tmo = (w >= TIMEOUT);
        n_acc = tmo ? TIMEOUT : w + 1;

        drive_req();
        #1;
        check("grant_ready0", req0_ready, win == 0);
        check("grant_ready1", req1_ready, win == 1);

        @(negedge pclk);  // SETUP
        pend[win] = 1'b0;
        drive_req();
        drive_slaves(-1, 1'b0, '0, 1'b0);
        #1;
        check("setup_psel", psel, (sel == 1) ? 2'b10 : 2'b01);
        check("setup_penable", penable, 0);
        check("setup_paddr", paddr, a);
        check("setup_pwrite", pwrite, wr);
        if (wr) check("setup_pwdata", pwdata, d);

        for (int k = 1; k <= n_acc; k++) begin
            @(negedge pclk);  // ACCESS
            drive_slaves(sel, (k == w + 1), rd, se);
            if (k == rst_k) begin
                pready0 = 1'b0; pready1 = 1'b0;
                preset = 1'b1;
            end
            #1;
            check("acc_psel", psel, (sel == 1) ? 2'b10 : 2'b01);
            check("acc_penable", penable, 1);
            check("acc_paddr", paddr, a);
            check("acc_ready", {req1_ready, req0_ready}, 0);
            check("acc_rsp", {rsp1_valid, rsp0_valid}, 0);
            if (k == rst_k) begin
                @(negedge pclk);
                preset = 1'b0;
                pend[win] = 1'b1;  // requester had it accepted; model re-queues nothing lost
                pend[win] = 1'b0;
                ptr = 0;
                drive_slaves(-1, 1'b0, '0, 1'b0);
                #1;
                check("rst_psel", psel, 0);
                check("rst_penable", penable, 0);
                check("rst_rsp", {rsp1_valid, rsp0_valid}, 0);
                return;
            end
        end

        @(negedge pclk);  // response cycle, back in IDLE
        drive_slaves(-1, 1'b0, '0, 1'b0);
        #1;
        check("rsp_psel", psel, 0);
        check("rsp_penable", penable, 0);
        check("rsp_valid", {rsp1_valid, rsp0_valid}, (win == 1) ? 2'b10 : 2'b01);
        check("rsp_rdata", (win == 1) ? rsp1_rdata : rsp0_rdata, (wr || tmo) ? '0 : rd);
        check("rsp_err", (win == 1) ? rsp1_err : rsp0_err, tmo ? 1'b1 : se);
    endtask

    initial begin
        int win, w;
        preset = 1'b1;
        pend[0] = 0; pend[1] = 0;
        for (int n = 0; n < 2; n++) begin c_wr[n] = 0; c_addr[n] = '0; c_data[n] = '0; end
        ptr = 0;
        issue(0, 1'b1, 8'h01, 8'h11);
        issue(1, 1'b1, 8'h81, 8'h22);
        drive_req();
        drive_slaves(-1, 1'b0, '0, 1'b0);

        // reset held two cycles with both requesters valid
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            #1;
            check("reset_psel", psel, 0);
            check("reset_penable", penable, 0);
            check("reset_ready", {req1_ready, req0_ready}, 0);
            check("reset_rsp", {rsp1_valid, rsp0_valid}, 0);
        end
        preset = 1'b0;

        // both continuously valid: strict alternation starting with req0
        for (int i = 0; i < 4; i++) begin
            serve(0, DW'($urandom), 1'b0, 0, win);
            check("alternation", win, i % 2);
            issue(win, 1'b0, AW'($urandom), DW'($urandom));
        end
        // drain both pending requests
        serve(1, 8'h44, 1'b0, 0, win);
        serve(0, 8'h55, 1'b0, 0, win);

        // directed cases
        issue(0, 1'b1, 8'h12, 8'hA5);
        serve(0, 8'hEE, 1'b0, 0, win);           // zero-wait write to slave0
        issue(1, 1'b0, 8'h85, 8'h00);
        serve(2, 8'h3C, 1'b0, 0, win);           // read slave1 with 2 wait states
        issue(0, 1'b0, 8'h20, 8'h00);
        serve(TIMEOUT + 5, 8'h77, 1'b0, 0, win); // hung slave0 -> timeout
        issue(0, 1'b0, 8'h30, 8'h00);
        serve(TIMEOUT - 1, 8'h5A, 1'b0, 0, win); // pready on the limit cycle wins
        issue(1, 1'b0, 8'h90, 8'h00);
        serve(0, 8'h11, 1'b1, 0, win);           // pslverr from slave1
        issue(1, 1'b1, 8'h81, 8'h66);
        serve(3, 8'h00, 1'b0, 2, win);           // reset in the middle of ACCESS
        issue(1, 1'b1, 8'h82, 8'h67);
        issue(0, 1'b0, 8'h03, 8'h00);
        serve(0, 8'h99, 1'b0, 0, win);           // pointer back at req0 after reset
        check("post_reset_winner", win, 0);
        serve(1, 8'h98, 1'b0, 0, win);

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            for (int n = 0; n < 2; n++)
                if (!pend[n] && ($urandom_range(0, 9) < 6))
                    issue(n, 1'($urandom), AW'($urandom), DW'($urandom));
            if (!pend[0] && !pend[1]) begin
                idle_cycle();
            end else begin
                if ($urandom_range(0, 9) < 7) w = $urandom_range(0, 3);
                else w = TIMEOUT - 2 + $urandom_range(0, 3);
                serve(w, DW'($urandom), 1'($urandom_range(0, 3) == 0), 0, win);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
